// File: rtl/conv_pkg.sv
// Shared layer geometry and writer state encoding for the convolution loop nest.
// The loop-counter side imports the same constants so both ends agree on layer shape.
package conv_pkg;

    localparam int DATA_W      = 16;
    localparam int ACC_W       = 32;
    localparam int K_SIZE      = 5;
    localparam int IN_GROUPS   = 1;
    localparam int OUT_SIZE    = 28;
    localparam int OUT_CHANNEL = 6;

    localparam int TERMS   = K_SIZE * K_SIZE * IN_GROUPS;
    localparam int NEURONS = OUT_CHANNEL * OUT_SIZE * OUT_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sat_relu.sv
// Combinational narrowing of a wide signed accumulator to a saturated DATA_W result,
// with an optional ReLU clamp applied after saturation.
module sat_relu #(
    parameter int ACC_W  = 32,
    parameter int DATA_W = 16,
    parameter int RELU   = 1
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] data_out
);

    localparam logic signed [ACC_W-1:0] MAX_VAL = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_VAL = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] sat_val;

    always_comb begin
        sat_val = acc[DATA_W-1:0];
        if ($signed(acc) > MAX_VAL) begin
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        end else if ($signed(acc) < MIN_VAL) begin
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        end
        if ((RELU != 0) && sat_val[DATA_W-1]) begin
            sat_val = '0;
        end
        data_out = sat_val;
    end

endmodule

// File: rtl/conv_out_writer.sv
// Writeback end of the convolution loop nest: sums TERMS partial products per neuron,
// saturates/ReLUs the sum and writes it to the output buffer at a row-major linear address.
module conv_out_writer #(
    parameter int DATA_W      = conv_pkg::DATA_W,
    parameter int ACC_W       = conv_pkg::ACC_W,
    parameter int ADDR_W      = 13,
    parameter int K_SIZE      = conv_pkg::K_SIZE,
    parameter int IN_GROUPS   = conv_pkg::IN_GROUPS,
    parameter int OUT_SIZE    = conv_pkg::OUT_SIZE,
    parameter int OUT_CHANNEL = conv_pkg::OUT_CHANNEL,
    parameter int RELU        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              layer_done
);

    import conv_pkg::*;

    localparam int TERMS_N   = K_SIZE * K_SIZE * IN_GROUPS;
    localparam int NEURONS_N = OUT_CHANNEL * OUT_SIZE * OUT_SIZE;
    localparam int CNT_W     = $clog2(TERMS_N + 1);

    localparam logic [CNT_W-1:0]  LAST_TERM = CNT_W'(TERMS_N - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NEURONS_N - 1);

    state_t             state;
    logic [CNT_W-1:0]   term_cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   term_ext;
    logic [ACC_W-1:0]   acc_new;
    logic [DATA_W-1:0]  sat_data;

    assign in_ready   = (state == ACCUM);
    assign wr_valid   = (state == EMIT);
    assign busy       = (state != IDLE);
    assign layer_done = (state == DONE);

    // The first term of a neuron overwrites the accumulator, so no separate clear cycle is needed.
    assign term_ext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign acc_new  = (term_cnt == '0) ? term_ext : (acc + term_ext);

    sat_relu #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W),
        .RELU  (RELU)
    ) u_sat_relu (
        .acc     (acc_new),
        .data_out(sat_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            term_cnt <= '0;
            acc      <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        term_cnt <= '0;
                        wr_addr  <= '0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_new;
                        if (term_cnt == LAST_TERM) begin
                            term_cnt <= '0;
                            wr_data  <= sat_data;
                            state    <= EMIT;
                        end else begin
                            term_cnt <= term_cnt + 1'b1;
                        end
                    end
                end
                // Loop order m, r, c is row-major, so the next address is always +1.
                EMIT: begin
                    if (wr_ready) begin
                        if (wr_addr == LAST_ADDR) begin
                            state <= DONE;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                            state   <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    wr_addr <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_out_writer.sv
// Bench for conv_out_writer: two instances (ReLU on / off) share one stimulus stream and
// are compared every cycle against a sum-and-clamp model, plus literal expectations.
module tb_conv_out_writer;

    localparam int DW      = 16;
    localparam int KS      = 5;
    localparam int IG      = 1;
    localparam int OS      = 4;
    localparam int OC      = 2;
    localparam int TERMS   = KS * KS * IG;
    localparam int NEURONS = OC * OS * OS;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic          wr_ready = 1'b1;
    logic [DW-1:0] in_data  = '0;

    logic          a_in_ready, a_wr_valid, a_busy, a_layer_done;
    logic [12:0]   a_wr_addr;
    logic [DW-1:0] a_wr_data;
    logic          b_in_ready, b_wr_valid, b_busy, b_layer_done;
    logic [12:0]   b_wr_addr;
    logic [DW-1:0] b_wr_data;

    int checks       = 0;
    int errors       = 0;
    int layer_writes = 0;

    int            m_phase     = 0;
    int            m_terms     = 0;
    int            m_addr      = 0;
    longint        m_sum       = 0;
    logic [DW-1:0] m_data_relu = '0;
    logic [DW-1:0] m_data_raw  = '0;

    conv_out_writer #(
        .DATA_W(DW), .ACC_W(32), .ADDR_W(13), .K_SIZE(KS), .IN_GROUPS(IG),
        .OUT_SIZE(OS), .OUT_CHANNEL(OC), .RELU(1)
    ) dut_relu (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_data(in_data), .wr_valid(a_wr_valid),
        .wr_ready(wr_ready), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .layer_done(a_layer_done)
    );

    conv_out_writer #(
        .DATA_W(DW), .ACC_W(32), .ADDR_W(13), .K_SIZE(KS), .IN_GROUPS(IG),
        .OUT_SIZE(OS), .OUT_CHANNEL(OC), .RELU(0)
    ) dut_raw (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_data(in_data), .wr_valid(b_wr_valid),
        .wr_ready(wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .layer_done(b_layer_done)
    );

    always #5 clk = ~clk;

    function automatic longint next_sum(input int terms, input longint sum, input logic [DW-1:0] d);
        longint v;
        v = longint'(signed'(d));
        return (terms == 0) ? v : sum + v;
    endfunction

    // Neuron result from the plain integer sum: wrap to 32 bits, clamp to 16, optional ReLU.
    function automatic logic [DW-1:0] model_result(input longint sum, input bit relu);
        logic signed [31:0] w;
        longint             v;
        logic [DW-1:0]      r;
        w = sum[31:0];
        v = longint'(w);
        if (v > 32767)       r = 16'h7FFF;
        else if (v < -32768) r = 16'h8000;
        else                 r = w[DW-1:0];
        if (relu && r[DW-1]) r = '0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase     <= 0;
            m_terms     <= 0;
            m_sum       <= 0;
            m_addr      <= 0;
            m_data_relu <= '0;
            m_data_raw  <= '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_terms <= 0;
                    m_addr  <= 0;
                end
                1: if (in_valid) begin
                    m_sum <= next_sum(m_terms, m_sum, in_data);
                    if (m_terms == TERMS - 1) begin
                        m_terms     <= 0;
                        m_phase     <= 2;
                        m_data_relu <= model_result(next_sum(m_terms, m_sum, in_data), 1'b1);
                        m_data_raw  <= model_result(next_sum(m_terms, m_sum, in_data), 1'b0);
                    end else begin
                        m_terms <= m_terms + 1;
                    end
                end
                2: if (wr_ready) begin
                    if (m_addr == NEURONS - 1) begin
                        m_phase <= 3;
                    end else begin
                        m_addr  <= m_addr + 1;
                        m_phase <= 1;
                    end
                end
                default: begin
                    m_addr  <= 0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        check_output("a_in_ready", 32'(a_in_ready), 32'(m_phase == 1));
        check_output("b_in_ready", 32'(b_in_ready), 32'(m_phase == 1));
        check_output("a_wr_valid", 32'(a_wr_valid), 32'(m_phase == 2));
        check_output("b_wr_valid", 32'(b_wr_valid), 32'(m_phase == 2));
        check_output("a_busy", 32'(a_busy), 32'(m_phase != 0));
        check_output("b_busy", 32'(b_busy), 32'(m_phase != 0));
        check_output("a_layer_done", 32'(a_layer_done), 32'(m_phase == 3));
        check_output("b_layer_done", 32'(b_layer_done), 32'(m_phase == 3));
        check_output("a_wr_addr", 32'(a_wr_addr), 32'(m_addr));
        check_output("b_wr_addr", 32'(b_wr_addr), 32'(m_addr));
        if (m_phase == 2) begin
            check_output("a_wr_data", 32'(a_wr_data), 32'(m_data_relu));
            check_output("b_wr_data", 32'(b_wr_data), 32'(m_data_raw));
        end
        if (a_wr_valid && wr_ready) layer_writes++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus_start;
        start = 1'b1;
        step();
        start = 1'b0;
        layer_writes = 0;
    endtask

    // Drives in_valid (with gap_pct percent idle cycles) until n terms have been accepted.
    task automatic apply_stimulus(input int n, input logic [DW-1:0] v, input logic [DW-1:0] inc,
                                  input int gap_pct);
        int            sent  = 0;
        int            guard = 0;
        logic [DW-1:0] cur   = v;
        while (sent < n && guard < 2000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = cur;
            @(negedge clk);
            if (in_valid && m_phase == 1) begin
                sent++;
                cur = cur + inc;
            end
            step();
            guard++;
        end
        in_valid = 1'b0;
        if (sent < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL feed_timeout: accepted=%0d required=%0d", sent, n);
        end
    endtask

    task automatic check_write(input logic [DW-1:0] exp_a, input logic [DW-1:0] exp_b, input int addr);
        @(negedge clk);
        check_output("lit_wr_valid", 32'(a_wr_valid), 32'd1);
        check_output("lit_in_ready_emit", 32'(a_in_ready), 32'd0);
        check_output("lit_a_data", 32'(a_wr_data), 32'(exp_a));
        check_output("lit_b_data", 32'(b_wr_data), 32'(exp_b));
        check_output("lit_addr", 32'(a_wr_addr), 32'(addr));
    endtask

    initial begin
        int k;
        #1 rst_n = 1'b0;
        step();
        step();
        check_output("rst_busy", 32'(a_busy), 32'd0);
        check_output("rst_addr", 32'(a_wr_addr), 32'd0);
        rst_n = 1'b1;
        step();

        // Reset mid-accumulation discards the partial neuron.
        apply_stimulus_start();
        apply_stimulus(10, 16'd7, 16'd0, 0);
        rst_n = 1'b0;
        #1;
        check_output("midrst_in_ready", 32'(a_in_ready), 32'd0);
        check_output("midrst_busy", 32'(a_busy), 32'd0);
        check_output("midrst_wr_valid", 32'(a_wr_valid), 32'd0);
        check_output("midrst_wr_data", 32'(a_wr_data), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        apply_stimulus_start();
        apply_stimulus(TERMS, 16'd1, 16'd0, 0);
        check_write(16'd25, 16'd25, 0);
        step();
        apply_stimulus(TERMS, 16'hFFFF, 16'd0, 0);
        check_write(16'h0000, 16'hFFE7, 1);
        step();
        apply_stimulus(TERMS, 16'h7FFF, 16'd0, 0);
        check_write(16'h7FFF, 16'h7FFF, 2);
        step();
        apply_stimulus(TERMS, 16'h8000, 16'd0, 0);
        check_write(16'h0000, 16'h8000, 3);
        step();

        // Gapped input, stray start, and a stalled write; terms 100,97,..,28 sum to 1600.
        wr_ready = 1'b0;
        start    = 1'b1;
        apply_stimulus(TERMS, 16'd100, 16'hFFFD, 40);
        start = 1'b0;
        check_write(16'd1600, 16'd1600, 4);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        for (int s = 0; s < 3; s++) begin
            step();
            @(negedge clk);
            check_output("stall_valid", 32'(a_wr_valid), 32'd1);
            check_output("stall_data", 32'(a_wr_data), 32'd1600);
            check_output("stall_addr", 32'(a_wr_addr), 32'd4);
        end
        step();
        in_valid = 1'b0;
        wr_ready = 1'b1;
        step();

        for (int n = 5; n < NEURONS; n++) begin
            apply_stimulus(TERMS, 16'(n * 37 - 500), 16'(n - 16), 20);
        end
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (a_layer_done) break;
            k++;
        end
        check_output("done_latency", 32'(k), 32'd1);
        check_output("done_busy", 32'(a_busy), 32'd1);
        check_output("layer_writes", 32'(layer_writes), 32'(NEURONS));
        @(negedge clk);
        check_output("done_pulse_end", 32'(a_layer_done), 32'd0);
        check_output("busy_fall", 32'(a_busy), 32'd0);
        step();

        apply_stimulus_start();
        apply_stimulus(TERMS, 16'd2, 16'd0, 0);
        check_write(16'd50, 16'd50, 0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
